// File: rtl/uart_tx_buffer.sv
// Transmit byte buffer for the UART transmitter: host-side FIFO plus a
// launch controller that issues one start pulse per byte and waits for done.
module uart_tx_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_din,
  input  logic              tx_done_tick,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   wptr, rptr, rptr_nxt;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  tx_din_nxt;
  logic               tx_start_nxt;
  logic               write_en;

  // Occupancy flags come straight from the registered pointers.
  assign count    = wptr - rptr;
  assign full     = (count == PTR_W'(DEPTH));
  assign empty    = (count == PTR_W'(0));
  assign busy     = (state == ST_WAIT);
  assign write_en = wr && !full;

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wptr[ADDR_W-1:0]] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
    end else if (write_en) begin
      wptr <= wptr + PTR_W'(1);
    end
  end

  // Set wins over clear when both happen in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wr && full) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      rptr     <= '0;
      tx_start <= 1'b0;
      tx_din   <= '0;
    end else begin
      state    <= state_nxt;
      rptr     <= rptr_nxt;
      tx_start <= tx_start_nxt;
      tx_din   <= tx_din_nxt;
    end
  end

  // Launch only from IDLE, so a done tick always costs one idle cycle.
  always_comb begin
    state_nxt    = state;
    rptr_nxt     = rptr;
    tx_start_nxt = 1'b0;
    tx_din_nxt   = tx_din;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          tx_din_nxt   = mem[rptr[ADDR_W-1:0]];
          rptr_nxt     = rptr + PTR_W'(1);
          tx_start_nxt = 1'b1;
          state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_done_tick) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: expected launches are queued as stimulus is
// applied and a monitor pops and compares them whenever tx_start appears.
module tb_uart_tx_buffer;

  logic       clk, reset, wr, clr_overflow, tx_done_tick, force_tick, done_w;
  logic [7:0] w_data;
  logic       full, empty, overflow, tx_start, busy;
  logic [4:0] count;
  logic [7:0] tx_din;

  uart_tx_buffer #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .wr(wr), .w_data(w_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .clr_overflow(clr_overflow), .tx_start(tx_start), .tx_din(tx_din),
    .tx_done_tick(done_w), .busy(busy)
  );

  assign done_w = tx_done_tick | force_tick;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int starts_seen = 0;
  int n_push = 0;
  int n_drop = 0;
  int tx_lat = 5;
  logic hold = 1'b0;
  logic check_gap = 1'b0;

  // Reference state: a byte queue standing in for the FIFO plus launch state.
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] launch_log[$];
  logic       m_wait, m_ovf, m_start;
  logic [7:0] m_din;
  int         mb_sz;
  logic [7:0] mb_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_wait  <= 1'b0;
      m_ovf   <= 1'b0;
      m_start <= 1'b0;
      m_din   <= 8'h00;
      fifo_q.delete();
      exp_q.delete();
    end else begin
      mb_sz = fifo_q.size();
      m_start <= 1'b0;
      if (!m_wait && mb_sz != 0) begin
        mb_b = fifo_q.pop_front();
        m_din   <= mb_b;
        m_start <= 1'b1;
        m_wait  <= 1'b1;
        exp_q.push_back(mb_b);
      end else if (m_wait && done_w) begin
        m_wait <= 1'b0;
      end
      if (wr && mb_sz < 16) begin
        fifo_q.push_back(w_data);
        n_push++;
      end
      if (wr && mb_sz == 16) begin
        m_ovf <= 1'b1;
        n_drop++;
      end else if (clr_overflow) begin
        m_ovf <= 1'b0;
      end
    end
  end

  // Monitor: status every cycle, launched byte against the queue on tx_start.
  always @(negedge clk) begin
    chk("count", 32'(count), 32'(fifo_q.size()));
    chk("full", 32'(full), 32'(fifo_q.size() == 16));
    chk("empty", 32'(empty), 32'(fifo_q.size() == 0));
    chk("busy", 32'(busy), 32'(m_wait));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tx_start", 32'(tx_start), 32'(m_start));
    chk("tx_din_hold", 32'(tx_din), 32'(m_din));
    if (tx_start) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL launch_unexpected: got %0h expected no launch (cycle %0d)", tx_din, cyc);
      end else begin
        chk("launch_byte", 32'(tx_din), 32'(exp_q.pop_front()));
      end
      launch_log.push_back(tx_din);
      if (check_gap) chk("launch_gap", 32'(cyc - last_done_cyc), 32'(2));
      starts_seen++;
    end
    if (done_w) last_done_cyc = cyc;
  end

  // Transmitter model: done tick tx_lat cycles after start, held off by hold.
  initial begin
    tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && reset) begin
        int lat;
        lat = tx_lat;
        for (int i = 0; i < lat; i++) begin
          @(posedge clk);
          if (!reset) break;
        end
        while (hold && reset) @(posedge clk);
        if (reset) begin
          #1 tx_done_tick = 1'b1;
          @(posedge clk);
          #1 tx_done_tick = 1'b0;
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic write_byte(input logic [7:0] b);
    wr = 1'b1;
    w_data = b;
    @(posedge clk);
    #1 wr = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    for (int i = 0; i < 2000; i++) begin
      if (starts_seen >= n) break;
      @(posedge clk);
    end
    chk("wait_start", 32'(starts_seen >= n), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (empty && !busy) break;
      @(posedge clk);
    end
    chk("wait_idle", 32'(empty && !busy), 32'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    int p0;
    int l0;
    reset = 1'b1;
    wr = 1'b0;
    w_data = 8'h00;
    clr_overflow = 1'b0;
    force_tick = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // 1: reset mid-transfer, then single-byte launch latency
    tx_lat = 20;
    write_byte(8'h5A);
    write_byte(8'h6B);
    repeat (4) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_tx_start", 32'(tx_start), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    tx_lat = 5;
    write_byte(8'hA5);
    @(negedge clk);
    chk("t1_start_early", 32'(tx_start), 32'(0));
    @(negedge clk);
    chk("t1_start", 32'(tx_start), 32'(1));
    chk("t1_din", 32'(tx_din), 32'(8'hA5));
    @(negedge clk);
    chk("t1_start_pulse", 32'(tx_start), 32'(0));
    chk("t1_busy", 32'(busy), 32'(1));
    @(posedge clk);
    #1;
    wait_idle(100);

    // 2: three bytes back-to-back, 160-cycle frames, 2-cycle relaunch gap
    tx_lat = 160;
    s0 = starts_seen;
    l0 = launch_log.size();
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    wait_starts(s0 + 1);
    check_gap = 1'b1;
    wait_starts(s0 + 3);
    check_gap = 1'b0;
    wait_idle(1000);
    chk("t2_n", 32'(launch_log.size() - l0), 32'(3));
    chk("t2_b0", 32'(launch_log[l0]), 32'(8'h11));
    chk("t2_b1", 32'(launch_log[l0 + 1]), 32'(8'h22));
    chk("t2_b2", 32'(launch_log[l0 + 2]), 32'(8'h33));

    // 3: stall the transmitter, fill to 16, overflow on the 18th write
    hold = 1'b1;
    tx_lat = 3;
    l0 = launch_log.size();
    for (int i = 0; i < 17; i++) write_byte(8'(i));
    @(negedge clk);
    chk("t3_count", 32'(count), 32'(16));
    chk("t3_full", 32'(full), 32'(1));
    chk("t3_busy", 32'(busy), 32'(1));
    chk("t3_ovf_pre", 32'(overflow), 32'(0));
    @(posedge clk);
    #1;
    write_byte(8'h11);
    @(negedge clk);
    chk("t3_ovf", 32'(overflow), 32'(1));
    chk("t3_count_drop", 32'(count), 32'(16));

    // 4: set beats clear when simultaneous; clear alone then takes effect
    @(posedge clk);
    #1;
    wr = 1'b1;
    w_data = 8'h99;
    clr_overflow = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    @(negedge clk);
    chk("t4_set_wins", 32'(overflow), 32'(1));
    @(posedge clk);
    #1 clr_overflow = 1'b0;
    @(negedge clk);
    chk("t4_cleared", 32'(overflow), 32'(0));
    @(posedge clk);
    #1 hold = 1'b0;
    wait_idle(2000);
    chk("t3_n", 32'(launch_log.size() - l0), 32'(17));
    for (int i = 0; i < 17; i++) chk("t3_order", 32'(launch_log[l0 + i]), 32'(i));

    // 5: stray done tick in IDLE, then random bursts with random frame time
    force_tick = 1'b1;
    @(posedge clk);
    #1 force_tick = 1'b0;
    @(negedge clk);
    chk("t5_idle_busy", 32'(busy), 32'(0));
    chk("t5_idle_start", 32'(tx_start), 32'(0));
    @(negedge clk);
    chk("t5_idle_start2", 32'(tx_start), 32'(0));
    @(posedge clk);
    #1;
    p0 = n_push;
    l0 = launch_log.size();
    for (int k = 0; k < 40; k++) begin
      int len;
      tx_lat = $urandom_range(1, 40);
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) write_byte(8'($urandom));
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #1;
    end
    wait_idle(20000);
    chk("t5_launched", 32'(launch_log.size() - l0), 32'(n_push - p0));
    chk("t5_exp_drained", 32'(exp_q.size()), 32'(0));
    chk("t5_fifo_drained", 32'(fifo_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
Transmit-side byte buffer and launch controller that sits directly upstream of the UART transmitter. It accepts bytes from a host write port into a 2^ADDR_W-deep FIFO and launches each byte into the transmitter with a single-cycle start pulse. It holds the byte on tx_din and waits for the transmitter's completion tick before launching the next byte. It also reports FIFO occupancy and a sticky overflow flag.

Parameters:
DATA_W, 8, byte width; must match the transmitter data width
ADDR_W, 4, FIFO address width; depth = 2^ADDR_W (16)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
wr  in  1  host write strobe; one byte per cycle when high
w_data  in  DATA_W  host write data, sampled when wr=1
full  out  1  FIFO holds 2^ADDR_W entries
empty  out  1  FIFO holds 0 entries
count  out  ADDR_W+1  current number of FIFO entries, 0..2^ADDR_W
overflow  out  1  sticky; set when a write arrives while full
clr_overflow  in  1  clears overflow
tx_start  out  1  one-cycle launch pulse to transmitter
tx_din  out  DATA_W  byte for transmitter; stable from the tx_start cycle until tx_done_tick
tx_done_tick  in  1  one-cycle completion pulse from transmitter
busy  out  1  high while a byte is in flight (state WAIT)

Behaviour:
- Reset (reset=0, asynchronous): FIFO pointers = 0, state = IDLE, tx_start=0, tx_din=0, overflow=0, busy=0. Resulting outputs: empty=1, full=0, count=0. Reset mid-transfer discards all FIFO contents and any in-flight status. Buffered bytes are not retained.
- FIFO storage: write/read pointers are ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1).
  - count = wptr - rptr, with the subtraction done modulo 2^(ADDR_W+1).
  - full = (count == 2^ADDR_W); empty = (count == 0).
  - All flags are registered-pointer derived and valid in the cycle after the updating edge.
- Write: wr=1 and full=0 → store w_data at wptr[ADDR_W-1:0] and increment wptr.
  - wr=1 and full=1 → data dropped, pointers unchanged, overflow set to 1 at that edge.
  - full is evaluated before any same-cycle pop, so a write while full is dropped even if a pop occurs in that cycle.
- overflow: set-dominant. An overflow event and clr_overflow in the same cycle leave overflow=1. clr_overflow alone clears it at the next edge.
- Controller FSM, 2 states:
  - IDLE: busy=0. If empty=0, at the next edge:
    - tx_din <= FIFO[rptr]
    - rptr increments
    - tx_start <= 1 for exactly one cycle
    - state <= WAIT
  - WAIT: busy=1, tx_start=0, tx_din held. On tx_done_tick=1 → IDLE at the next edge.
- tx_done_tick in IDLE is ignored.
- A new launch is never issued in the same cycle tx_done_tick is seen. The minimum gap is one IDLE cycle after the done tick, during which the transmitter has itself returned to idle.
- Latency: a write accepted at edge N into an empty FIFO with state IDLE gives empty=0 after edge N. tx_start is high in the cycle following edge N+1, i.e. 2 cycles after the write cycle.
- Simultaneous write and pop (non-full, non-empty): both occur; count is unchanged.
- count, full and empty reflect the pop at the launch edge; a byte in flight is not counted.
- Throughput: one byte per transmitter frame plus one cycle.

Test Plan:
1. Reset low mid-run → immediately empty=1, count=0, full=0, tx_start=0, busy=0, overflow=0. Release and write 0xA5 → tx_start pulses 1 cycle with tx_din=0xA5 two cycles after the write, busy=1.
2. Write 0x11, 0x22, 0x33 back-to-back while the transmitter model returns tx_done_tick 160 cycles after each start → three tx_start pulses in order 0x11, 0x22, 0x33. tx_din is stable between each start and its done tick. Each next start comes exactly 2 cycles after the prior done tick.
3. Hold the transmitter model (no done tick) after the first launch and write 17 bytes 0x00..0x10 → first byte in flight, count reaches 16, full=1. The 18th write (0x11) sets overflow=1 and is dropped. After releasing, the remaining bytes launch in order 0x01..0x10.
4. With full=1, assert wr and clr_overflow in the same cycle → overflow stays 1. clr_overflow alone one cycle later → overflow=0.
5. Pulse tx_done_tick while in IDLE with empty=1 → no state change, tx_start stays 0. Then 40 pseudo-random write bursts with random done latency → output byte sequence equals input sequence, with no lost or duplicated bytes except the logged overflow drops.
